// File: rtl/rf_rom_op_seq_pkg.sv
// Shared types and default widths for the RF/ROM operation sequencer.
package rf_rom_op_seq_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned RAM_AW_DEF = 4;

  // Command record {src1, src2, dst}
  localparam int unsigned CMD_W = 3 * ADDR_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOOKUP = 3'd2,
    S_WRITE  = 3'd3,
    S_STORE  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/rf_rom_op_seq_if.sv
// Command handshake bundle: the source drives start/src1/src2/dst, the sequencer returns cmd_ready.
interface rf_rom_op_seq_if #(
  parameter int unsigned ADDR_W = rf_rom_op_seq_pkg::ADDR_W_DEF
) ();

  logic              start;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [ADDR_W-1:0] dst;
  logic              cmd_ready;

  modport master (
    output start, src1, src2, dst,
    input  cmd_ready
  );

  modport slave (
    input  start, src1, src2, dst,
    output cmd_ready
  );

endinterface

// File: rtl/rf_rom_op_seq_cmd_pend_buf.sv
// One-deep pending command register; a load in the same cycle as a take keeps it valid.
module rf_rom_op_seq_cmd_pend_buf
  import rf_rom_op_seq_pkg::*;
#(
  parameter int unsigned W = CMD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_rom_op_seq.sv
// Sequencer: read two RF operands, look up ROM[{opa,opb}], write the result back to the RF.
// Define STORE_RAM_EN to also store each result to RAM at an auto-incrementing pointer.
module rf_rom_op_seq
  import rf_rom_op_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RAM_AW = RAM_AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  rf_rom_op_seq_if.slave      cmd,
  output logic [ADDR_W-1:0]   SA,
  output logic [ADDR_W-1:0]   SB,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] ROM_addr,
  input  logic [DATA_W-1:0]   ROM_data,
  output logic [ADDR_W-1:0]   DA,
  output logic                w_rf,
  output logic                w_ram,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W-1:0]   result,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int unsigned CW = 3 * ADDR_W;

  state_e            state;
  state_e            state_nx;
  logic              cmd_ready_q;
  logic              accept;
  logic              pend_load;
  logic              pend_take;
  logic              pend_valid;
  logic              pend_valid_nx;
  logic [CW-1:0]     pend_cmd;
  logic [CW-1:0]     new_cmd;
  logic [CW-1:0]     launch_cmd;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  assign cmd.cmd_ready = cmd_ready_q;
  assign new_cmd       = {cmd.src1, cmd.src2, cmd.dst};
  // A buffered command always wins over a fresh one when leaving IDLE
  assign launch_cmd    = pend_valid ? pend_cmd : new_cmd;
  assign ROM_addr      = {opa, opb};

  rf_rom_op_seq_cmd_pend_buf #(
    .W (CW)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .load  (pend_load),
    .take  (pend_take),
    .din   (new_cmd),
    .valid (pend_valid),
    .dout  (pend_cmd)
  );

  // Accept/buffer decisions and next state
  always_comb begin
    accept        = cmd.start & cmd_ready_q;
    pend_take     = (state == S_IDLE) & pend_valid;
    pend_load     = accept & ((state != S_IDLE) | pend_valid);
    pend_valid_nx = pend_load | (pend_valid & ~pend_take);
    state_nx      = state;
    unique case (state)
      S_IDLE:   if (pend_valid | accept) state_nx = S_READ;
      S_READ:   state_nx = S_LOOKUP;
      S_LOOKUP: state_nx = S_WRITE;
      S_WRITE: begin
`ifdef STORE_RAM_EN
        state_nx = S_STORE;
`else
        state_nx = S_DONE;
`endif
      end
      S_STORE:  state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register and registered datapath/control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b1;
      SA          <= '0;
      SB          <= '0;
      DA          <= '0;
      dst_q       <= '0;
      opa         <= '0;
      opb         <= '0;
      w_rf        <= 1'b0;
      result      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      cmd_ready_q <= (state_nx == S_IDLE) | ~pend_valid_nx;
      busy        <= (state_nx != S_IDLE);
      done        <= (state_nx == S_DONE);
      w_rf        <= (state_nx == S_WRITE);
      if (cmd.start & ~cmd_ready_q) overflow <= 1'b1;
      if ((state == S_IDLE) && (state_nx == S_READ)) {SA, SB, dst_q} <= launch_cmd;
      if (state == S_READ) begin
        opa <= a;
        opb <= b;
      end
      if (state == S_LOOKUP) DA <= dst_q;
      if (state == S_WRITE) result <= ROM_data;
    end
  end

`ifdef STORE_RAM_EN
  logic [RAM_AW-1:0] ptr;

  // RAM store port; ptr wraps naturally at 2^RAM_AW
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      w_ram     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      w_ram <= (state_nx == S_STORE);
      if (state == S_WRITE) begin
        ram_addr  <= ptr;
        ram_wdata <= ROM_data;
      end
      if (state == S_STORE) ptr <= ptr + RAM_AW'(1);
    end
  end
`else
  assign w_ram     = 1'b0;
  assign ram_addr  = '0;
  assign ram_wdata = '0;
`endif

endmodule

// File: tb/tb_rf_rom_op_seq.sv
// Bench for rf_rom_op_seq: RF/ROM environment plus a command-level reference model.
`define CHK(t, o, e) chk(t, 32'(o), 32'(e))

module tb_rf_rom_op_seq;

`ifdef STORE_RAM_EN
  localparam int LAT = 5;
  localparam bit ST  = 1'b1;
`else
  localparam int LAT = 4;
  localparam bit ST  = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] d;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rf_init = 1'b0;
  logic [2:0] SA, SB, DA;
  logic [3:0] a, b, ROM_data, result, ram_wdata, ram_addr;
  logic [7:0] ROM_addr;
  logic       w_rf, w_ram, busy, done, overflow;

  logic [3:0] rf_env [8];
  logic [3:0] rf_m   [8];
  logic [3:0] rom    [256];

  int   total = 0;
  int   bad   = 0;
  cmd_t pend_q[$];
  bit   ovf_m = 1'b0;
  logic [3:0] ptr_m = 4'd0;
  int   inj_n [2];
  cmd_t inj_c [2];

  rf_rom_op_seq_if #(.ADDR_W(3)) cif ();

  rf_rom_op_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif),
    .SA        (SA),
    .SB        (SB),
    .a         (a),
    .b         (b),
    .ROM_addr  (ROM_addr),
    .ROM_data  (ROM_data),
    .DA        (DA),
    .w_rf      (w_rf),
    .w_ram     (w_ram),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  assign a = rf_env[SA];
  assign b = rf_env[SB];

  // RF with combinational read, ROM with one-cycle registered read
  always @(posedge clk) begin
    ROM_data <= rom[ROM_addr];
    if (rf_init) rf_env <= rf_m;
    else if (w_rf) rf_env[DA] <= ROM_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.s1 = 3'($urandom_range(0, 7));
    c.s2 = 3'($urandom_range(0, 7));
    c.d  = 3'($urandom_range(0, 7));
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    cif.start = 1'b1;
    cif.src1  = c.s1;
    cif.src2  = c.s2;
    cif.dst   = c.d;
  endtask

  // Follow one operation whose READ begins at the next edge; optional start injections
  task automatic follow_op(input cmd_t c);
    logic [3:0] oa, ob, exp;
    oa  = rf_m[c.s1];
    ob  = rf_m[c.s2];
    exp = rom[{oa, ob}];
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      `CHK("busy", busy, n <= LAT);
      `CHK("done", done, n == LAT);
      `CHK("w_rf", w_rf, n == 3);
      `CHK("w_ram", w_ram, ST && (n == 4));
      `CHK("cmd_ready", cif.cmd_ready, (n == LAT + 1) || (pend_q.size() == 0));
      `CHK("overflow", overflow, ovf_m);
      if (n == 1) begin
        `CHK("SA", SA, c.s1);
        `CHK("SB", SB, c.s2);
      end
      if (n == 2) `CHK("ROM_addr", ROM_addr, {oa, ob});
      if (n == 3) `CHK("DA", DA, c.d);
`ifdef STORE_RAM_EN
      if (n == 4) begin
        `CHK("ram_addr", ram_addr, ptr_m);
        `CHK("ram_wdata", ram_wdata, exp);
      end
`else
      `CHK("ram_addr_tied", ram_addr, 4'd0);
      `CHK("ram_wdata_tied", ram_wdata, 4'd0);
`endif
      if (n == LAT) `CHK("result", result, exp);
      cif.start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (inj_n[k] == n) begin
          drive(inj_c[k]);
          if (pend_q.size() == 0) pend_q.push_back(inj_c[k]);
          else ovf_m = 1'b1;
        end
      end
    end
    rf_m[c.d] = exp;
    if (ST) ptr_m = ptr_m + 4'd1;
    inj_n[0] = 0;
    inj_n[1] = 0;
  endtask

  task automatic run_op(input cmd_t c);
    cmd_t p;
    follow_op(c);
    while (pend_q.size() != 0) begin
      p = pend_q.pop_front();
      follow_op(p);
    end
  endtask

  initial begin
    cmd_t ca, cb, cc;
    inj_n[0] = 0;
    inj_n[1] = 0;
    cif.start = 1'b0;
    cif.src1  = 3'd0;
    cif.src2  = 3'd0;
    cif.dst   = 3'd0;
    for (int i = 0; i < 256; i++) rom[i] = 4'($urandom);
    for (int i = 0; i < 8; i++) rf_m[i] = 4'($urandom);
    rf_m[0] = 4'h3;
    rf_m[1] = 4'h5;
    rom[8'h35] = 4'hF;
    rom[8'hF5] = 4'hA;

    // Reset state
    rst     = 1'b0;
    rf_init = 1'b1;
    repeat (3) @(negedge clk);
    `CHK("rst_cmd_ready", cif.cmd_ready, 1'b1);
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_done", done, 1'b0);
    `CHK("rst_w_rf", w_rf, 1'b0);
    `CHK("rst_w_ram", w_ram, 1'b0);
    `CHK("rst_overflow", overflow, 1'b0);
    `CHK("rst_result", result, 4'h0);
    `CHK("rst_SA", SA, 3'd0);
    `CHK("rst_DA", DA, 3'd0);
    `CHK("rst_ROM_addr", ROM_addr, 8'h00);
    `CHK("rst_ram_addr", ram_addr, 4'h0);
    `CHK("rst_ram_wdata", ram_wdata, 4'h0);
    rf_init = 1'b0;
    rst     = 1'b1;

    // Basic operation: RF[0]=3, RF[1]=5, ROM[0x35]=F -> RF[2]
    ca = '{s1: 3'd0, s2: 3'd1, d: 3'd2};
    drive(ca);
    run_op(ca);
    `CHK("basic_result", result, 4'hF);

    // Back-to-back with dependency, then a dropped third command
    cb = '{s1: 3'd2, s2: 3'd1, d: 3'd3};
    cc = '{s1: 3'd7, s2: 3'd6, d: 3'd5};
    inj_n[0] = 1; inj_c[0] = cb;
    inj_n[1] = 2; inj_c[1] = cc;
    drive(ca);
    follow_op(ca);
    `CHK("overflow_set", overflow, 1'b1);
    `CHK("pend_count", pend_q.size(), 1);
    cb = pend_q.pop_front();
    follow_op(cb);
    `CHK("dep_ROM_addr", ROM_addr, 8'hF5);
    `CHK("dep_result", result, 4'hA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $error("FAIL dropped_idle: observed=%0h expected=0", busy);
      end
    end

    // Start in the same cycle as DONE lands in the buffer
    inj_n[0] = LAT; inj_c[0] = rand_cmd();
    ca = rand_cmd();
    drive(ca);
    run_op(ca);

    // Randomised run; more than 16 results exercises the RAM pointer wrap
    for (int i = 0; i < 17; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        inj_n[0] = $urandom_range(1, LAT);
        inj_c[0] = rand_cmd();
      end
      ca = rand_cmd();
      drive(ca);
      run_op(ca);
    end
    `CHK("overflow_sticky", overflow, 1'b1);

    // Reset asserted during WRITE with a pending command
    ca = rand_cmd();
    drive(ca);
    @(negedge clk);
    drive(rand_cmd());
    @(negedge clk);
    cif.start = 1'b0;
    @(negedge clk);
    `CHK("pre_rst_w_rf", w_rf, 1'b1);
    rst = 1'b0;
    #1;
    `CHK("async_w_rf", w_rf, 1'b0);
    `CHK("async_busy", busy, 1'b0);
    `CHK("async_done", done, 1'b0);
    `CHK("async_overflow", overflow, 1'b0);
    `CHK("async_cmd_ready", cif.cmd_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pend_q.delete();
    ovf_m = 1'b0;
    ptr_m = 4'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $error("FAIL post_rst_busy: observed=%0h expected=0", busy);
      end
      total++;
      if (done !== 1'b0) begin
        bad++;
        $error("FAIL post_rst_done: observed=%0h expected=0", done);
      end
    end

    // Fresh command after reset
    ca = rand_cmd();
    drive(ca);
    run_op(ca);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
